// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
//
// Registered decode stage between instruction fetch and the immediate
// generator / register file. Each accepted instruction is classified into a
// 3-bit immediate-format code and flagged if its opcode is unknown. The result
// is presented one cycle later through a two-entry skid buffer: main register
// M drives the outputs, and skid register S catches one extra instruction
// while M is stalled.
//
// Handshakes (both sides use strict valid/ready semantics):
//   A transfer happens on a rising clk_in edge when valid and ready are both
//   high in the cycle before that edge. A valid source holds its payload
//   stable until the transfer. Ready may be raised or lowered freely.
//   Upstream:   instr_valid_in / instr_ready_out (instr_ready_out is a
//               register output with no combinational path from ready_in).
//   Downstream: valid_out / ready_in.
//
// Ports:
//   clk_in           clock, rising edge
//   rst_in           synchronous active-high reset
//   flush_in         discard every buffered instruction (and any input
//                    presented in the same cycle)
//   instr_in/pc_in   fetched instruction and its PC
//   instr_valid_in   upstream has an instruction
//   instr_ready_out  stage can accept an instruction (= skid entry empty)
//   instr_out/pc_out buffered instruction and PC (RESET_INSTR / 0 when empty)
//   imm_type_out     000 none, 001 I, 010 S, 011 B, 100 U, 101 J
//   rs1/rs2/rd_out   raw register fields of instr_out
//   illegal_out      unrecognised opcode
//   valid_out        outputs hold a decoded instruction
//   ready_in         downstream accepts this cycle
// ---------------------------------------------------------------------------
module instr_decode_stage #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            flush_in,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            instr_valid_in,
    output logic            instr_ready_out,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [2:0]      imm_type_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic            illegal_out,
    output logic            valid_out,
    input  logic            ready_in
);

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Combinational decode of the incoming instruction.
    logic [2:0] dec_imm;
    logic       dec_illegal;

    always_comb begin
        dec_imm     = IMM_NONE;
        dec_illegal = 1'b0;
        unique case (instr_in[6:0])
            OP_R:                       dec_imm = IMM_NONE;
            OP_IMM, OP_LOAD, OP_JALR:   dec_imm = IMM_I;
            OP_STORE:                   dec_imm = IMM_S;
            OP_BRANCH:                  dec_imm = IMM_B;
            OP_LUI, OP_AUIPC:           dec_imm = IMM_U;
            OP_JAL:                     dec_imm = IMM_J;
            OP_FENCE, OP_SYSTEM:        dec_imm = IMM_NONE;
            default:                    dec_illegal = 1'b1;
        endcase
    end

    // Main (output) entry.
    logic            m_valid;
    logic [XLEN-1:0] m_instr;
    logic [XLEN-1:0] m_pc;
    logic [2:0]      m_imm;
    logic            m_illegal;

    // Skid entry.
    logic            s_valid;
    logic [XLEN-1:0] s_instr;
    logic [XLEN-1:0] s_pc;
    logic [2:0]      s_imm;
    logic            s_illegal;

    logic in_xfer;
    logic out_xfer;
    logic m_free;

    assign instr_ready_out = ~s_valid;
    assign in_xfer         = instr_valid_in & instr_ready_out;
    assign out_xfer        = m_valid & ready_in;
    // M can take a new entry this edge if it is empty or being drained.
    assign m_free          = ~m_valid | out_xfer;

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            // Reset and flush leave the stage in the same idle state.
            m_valid   <= 1'b0;
            m_instr   <= RESET_INSTR;
            m_pc      <= '0;
            m_imm     <= IMM_NONE;
            m_illegal <= 1'b0;
            s_valid   <= 1'b0;
            s_instr   <= RESET_INSTR;
            s_pc      <= '0;
            s_imm     <= IMM_NONE;
            s_illegal <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                // Oldest pending instruction moves up; no input can arrive
                // in this cycle because instr_ready_out was already low.
                m_valid   <= 1'b1;
                m_instr   <= s_instr;
                m_pc      <= s_pc;
                m_imm     <= s_imm;
                m_illegal <= s_illegal;
                s_valid   <= 1'b0;
            end else if (in_xfer) begin
                m_valid   <= 1'b1;
                m_instr   <= instr_in;
                m_pc      <= pc_in;
                m_imm     <= dec_imm;
                m_illegal <= dec_illegal;
            end else begin
                // Empty M shows the idle NOP so downstream sees a benign word.
                m_valid   <= 1'b0;
                m_instr   <= RESET_INSTR;
                m_pc      <= '0;
                m_imm     <= IMM_NONE;
                m_illegal <= 1'b0;
            end
        end else if (in_xfer) begin
            // M stalled: park the new instruction in the skid entry.
            s_valid   <= 1'b1;
            s_instr   <= instr_in;
            s_pc      <= pc_in;
            s_imm     <= dec_imm;
            s_illegal <= dec_illegal;
        end
    end

    assign valid_out    = m_valid;
    assign instr_out    = m_instr;
    assign pc_out       = m_pc;
    assign imm_type_out = m_imm;
    assign illegal_out  = m_illegal;
    assign rs1_out      = m_instr[19:15];
    assign rs2_out      = m_instr[24:20];
    assign rd_out       = m_instr[11:7];

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
//
// Directed bench for instr_decode_stage. The driver records the expected
// decode for every instruction it presents; an input monitor pushes that
// expectation when the upstream handshake completes, and an output monitor
// pops and compares whenever valid_out & ready_in, and checks that outputs
// stay stable across stalls.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [2:0]  imm_type_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [4:0]  rd_out;
    logic        illegal_out;
    logic        valid_out;
    logic        ready_in;

    instr_decode_stage dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .flush_in        (flush_in),
        .instr_in        (instr_in),
        .pc_in           (pc_in),
        .instr_valid_in  (instr_valid_in),
        .instr_ready_out (instr_ready_out),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .imm_type_out    (imm_type_out),
        .rs1_out         (rs1_out),
        .rs2_out         (rs2_out),
        .rd_out          (rd_out),
        .illegal_out     (illegal_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    // {instr[31:0], pc[31:0], imm_type[2:0], illegal}
    logic [67:0] exp_q[$];
    logic [67:0] cur_exp;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [2:0] imm, input logic ill);
        instr_in       = instr;
        pc_in          = pc;
        instr_valid_in = 1'b1;
        cur_exp        = {instr, pc, imm, ill};
    endtask

    task automatic wait_accept();
        int  n;
        bit  acc;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            acc = instr_ready_out;
            tick();
            n++;
        end
        instr_valid_in = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=stalled required=accepted pc=%0h", pc_in);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [2:0] imm, input logic ill);
        present(instr, pc, imm, ill);
        wait_accept();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 96'(valid_out), 96'(0));
        check({tag, "_ready"}, 96'(instr_ready_out), 96'(1));
        check({tag, "_instr"}, 96'(instr_out), 96'(32'h0000_0013));
        check({tag, "_pc"}, 96'(pc_out), 96'(0));
        check({tag, "_imm"}, 96'(imm_type_out), 96'(0));
        check({tag, "_regs"}, 96'({rs1_out, rs2_out, rd_out}), 96'(0));
        check({tag, "_illegal"}, 96'(illegal_out), 96'(0));
    endtask

    // ---------------- input monitor ----------------
    always @(negedge clk_in) begin
        if (rst_in === 1'b0 && flush_in === 1'b0 &&
            instr_valid_in === 1'b1 && instr_ready_out === 1'b1)
            exp_q.push_back(cur_exp);
    end

    // ---------------- output monitor ----------------
    logic [83:0] prev_outs;
    bit          prev_stall = 1'b0;
    logic [83:0] outs;
    assign outs = {instr_out, pc_out, imm_type_out, rs1_out, rs2_out, rd_out, illegal_out, valid_out};

    always @(negedge clk_in) begin
        logic [67:0] e;
        if (prev_stall)
            check("stall_hold", 96'(outs), 96'(prev_outs));
        prev_outs  = outs;
        prev_stall = (valid_out === 1'b1) && (ready_in === 1'b0) &&
                     (rst_in === 1'b0) && (flush_in === 1'b0);
        if (rst_in !== 1'b0 || flush_in !== 1'b0) begin
            exp_q.delete();
        end else if (valid_out === 1'b1 && ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=pc_%0h required=no_output", pc_out);
            end else begin
                e = exp_q.pop_front();
                check("out_instr", 96'(instr_out), 96'(e[67:36]));
                check("out_pc", 96'(pc_out), 96'(e[35:4]));
                check("out_imm", 96'(imm_type_out), 96'(e[3:1]));
                check("out_illegal", 96'(illegal_out), 96'(e[0]));
                check("out_rs1", 96'(rs1_out), 96'(e[55:51]));
                check("out_rs2", 96'(rs2_out), 96'(e[60:56]));
                check("out_rd", 96'(rd_out), 96'(e[47:43]));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] op_tab[11]  = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                                7'b1101111, 7'b0001111, 7'b1110011};
    logic [2:0] imm_tab[11] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b011,
                                3'b100, 3'b100, 3'b101, 3'b000, 3'b000};
    bit stream_done;

    task automatic drain();
        int n;
        n = 0;
        ready_in = 1'b1;
        while ((exp_q.size() != 0 || valid_out === 1'b1) && n < 40) begin
            tick();
            n++;
        end
        check("drain_empty", 96'(exp_q.size()), 96'(0));
    endtask

    initial begin
        rst_in         = 1'b1;
        flush_in       = 1'b0;
        instr_in       = '0;
        pc_in          = '0;
        instr_valid_in = 1'b0;
        ready_in       = 1'b1;
        cur_exp        = '0;
        tick();
        tick();
        check_idle("reset");
        rst_in = 1'b0;
        tick();

        // Decode sweep, one per cycle, ready held high.
        send(32'hFFF0_0093, 32'h100, 3'b001, 1'b0);
        check("sweep_first_valid", 96'(valid_out), 96'(1));
        check("sweep_first_rd", 96'(rd_out), 96'(1));
        send(32'h0011_2623, 32'h104, 3'b010, 1'b0);
        check("sweep_store_rs", 96'({rs1_out, rs2_out}), 96'({5'd2, 5'd1}));
        send(32'hFE00_0EE3, 32'h108, 3'b011, 1'b0);
        send(32'h1234_50B7, 32'h10C, 3'b100, 1'b0);
        send(32'h0080_00EF, 32'h110, 3'b101, 1'b0);
        send(32'h0020_8033, 32'h114, 3'b000, 1'b0);
        send(32'hFFFF_FFFF, 32'h118, 3'b000, 1'b1);
        send(32'h0000_0000, 32'h11C, 3'b000, 1'b1);
        drain();

        // Back-pressure: M and S fill, third instruction held upstream.
        ready_in = 1'b0;
        send(32'h0010_0093, 32'h0, 3'b001, 1'b0);
        send(32'h0020_0113, 32'h4, 3'b001, 1'b0);
        present(32'h0030_0193, 32'h8, 3'b001, 1'b0);
        tick();
        tick();
        check("bp_ready_low", 96'(instr_ready_out), 96'(0));
        check("bp_hold_pc", 96'(pc_out), 96'(0));
        check("bp_hold_valid", 96'(valid_out), 96'(1));
        ready_in = 1'b1;
        wait_accept();
        drain();

        // Flush with both entries full; the presented instruction is dropped.
        ready_in = 1'b0;
        send(32'h0040_0213, 32'h20, 3'b001, 1'b0);
        send(32'h0050_0293, 32'h24, 3'b001, 1'b0);
        present(32'h0060_0313, 32'h28, 3'b001, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in       = 1'b0;
        instr_valid_in = 1'b0;
        check_idle("flush");
        // Flush while the stage would accept: the input must never appear.
        ready_in = 1'b1;
        present(32'h0070_0393, 32'h2C, 3'b001, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in       = 1'b0;
        instr_valid_in = 1'b0;
        tick();
        check("flush_drop_valid", 96'(valid_out), 96'(0));

        // Reset in the middle of a stall with both entries full.
        ready_in = 1'b0;
        send(32'hFFFF_FFFF, 32'h40, 3'b000, 1'b1);
        send(32'h0080_0413, 32'h44, 3'b001, 1'b0);
        rst_in = 1'b1;
        tick();
        check_idle("rst_stall");
        rst_in = 1'b0;
        tick();

        // Random legal stream with random back-pressure.
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int k;
                    logic [24:0] hi;
                    k  = $urandom_range(0, 10);
                    hi = 25'($urandom);
                    send({hi, op_tab[k]}, 32'h1000 + 32'(i * 4), imm_tab[k], 1'b0);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    ready_in = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
